// File: rtl/bram_ctrl_pkg.sv
// Shared types and sizes for the block-RAM port controller.
package bram_ctrl_pkg;

    localparam int ADDR_W         = 12;
    localparam int DATA_W         = 4;
    localparam int RSP_FIFO_DEPTH = 3;

    // RESET: held by RST, or the one cycle after it is released (clear pending)
    // CLEAR: sweeping every location to the fill value
    // RUN  : servicing the request stream
    // DRAIN: clear requested, waiting for the in-flight read to land
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/bram_rsp_fifo.sv
// Small in-order synchronous FIFO with an occupancy count.
// Push and pop in the same cycle leave the count unchanged; a push into a
// full FIFO is only taken when a pop frees a slot in the same cycle.
module bram_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is data only; validity is tracked by cnt, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/bram_s4_port_ctrl.sv
// Initiator for one port of a 4096 x 4 block RAM: request stream in,
// ADDR/DI/EN/WE/SSR pins out, read data back through a skid FIFO sized to
// cover the RAM's one-cycle read latency. Sweeps the array to FILL after
// reset and on clr_start.
module bram_s4_port_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] FILL       = 4'h0,
    parameter int                DEPTH_LOG2 = ADDR_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clr_start,
    output logic                  clr_busy,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DEPTH_LOG2-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [DEPTH_LOG2-1:0] ADDR,
    output logic [DATA_W-1:0]     DI,
    output logic                  EN,
    output logic                  WE,
    output logic                  SSR,
    input  logic [DATA_W-1:0]     DO
);

    localparam int CNT_W = $clog2(RSP_FIFO_DEPTH + 1);

    state_t                state;
    state_t                state_nx;
    logic [DEPTH_LOG2-1:0] clr_addr;
    logic                  pend;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [DATA_W-1:0]     fifo_head;
    logic [CNT_W:0]        occ;
    logic                  pop;

    // Reads in flight plus buffered responses; ready only while a new read
    // is guaranteed a FIFO slot, independent of rsp_ready.
    assign occ = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, pend};

    // Output reset of the RAM is never used.
    assign SSR = 1'b0;

    assign rsp_valid = !RST && (fifo_cnt != '0);
    assign rsp_rdata = rsp_valid ? fifo_head : '0;
    assign pop       = rsp_valid && rsp_ready;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_RESET;
        else     state <= state_nx;
    end

    // Next state and pin muxing; RST forces every output low combinationally.
    always_comb begin
        state_nx  = state;
        clr_busy  = 1'b0;
        req_ready = 1'b0;
        EN        = 1'b0;
        WE        = 1'b0;
        ADDR      = '0;
        DI        = '0;
        case (state)
            ST_RESET: state_nx = ST_CLEAR;
            ST_CLEAR: if (clr_addr == '1) state_nx = ST_RUN;
            ST_RUN:   if (clr_start) state_nx = ST_DRAIN;
            ST_DRAIN: if (!pend) state_nx = ST_CLEAR;
            default:  state_nx = ST_RESET;
        endcase
        if (!RST) begin
            case (state)
                ST_RESET: clr_busy = 1'b1;
                ST_CLEAR: begin
                    clr_busy = 1'b1;
                    EN       = 1'b1;
                    WE       = 1'b1;
                    ADDR     = clr_addr;
                    DI       = FILL;
                end
                ST_RUN: begin
                    req_ready = (occ < (CNT_W + 1)'(RSP_FIFO_DEPTH));
                    EN        = req_valid && req_ready;
                    WE        = EN && req_we;
                    ADDR      = req_addr;
                    DI        = req_wdata;
                end
                ST_DRAIN: clr_busy = 1'b1;
                default: ;
            endcase
        end
    end

    // Sweep counter; wraps back to 0 on the last location so the next
    // clear starts from the bottom again.
    always_ff @(posedge CLK) begin
        if (RST)                    clr_addr <= '0;
        else if (state == ST_CLEAR) clr_addr <= clr_addr + 1'b1;
    end

    // A read issued this cycle has DO valid next cycle.
    always_ff @(posedge CLK) begin
        if (RST) pend <= 1'b0;
        else     pend <= EN && !WE;
    end

    bram_rsp_fifo #(
        .DEPTH (RSP_FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk  (CLK),
        .rst  (RST),
        .push (pend),
        .din  (DO),
        .pop  (pop),
        .dout (fifo_head),
        .cnt  (fifo_cnt)
    );

endmodule

// File: tb/tb_bram_s4_port_ctrl.sv
// Bench for bram_s4_port_ctrl: behavioural WRITE_FIRST RAM on the pins,
// shadow memory for expected read data, and a response scoreboard.
module tb_bram_s4_port_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        clr_start;
    logic        clr_busy;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [3:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_rdata;
    logic [11:0] ADDR;
    logic [3:0]  DI;
    logic        EN;
    logic        WE;
    logic        SSR;
    logic [3:0]  DO;

    localparam logic [3:0] FILLV = 4'hA;

    bram_s4_port_ctrl #(.FILL(FILLV), .DEPTH_LOG2(12)) dut (
        .CLK(CLK), .RST(RST), .clr_start(clr_start), .clr_busy(clr_busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ADDR(ADDR), .DI(DI), .EN(EN), .WE(WE), .SSR(SSR), .DO(DO)
    );

    always #5 CLK = ~CLK;

    // RAM primitive model: registered output, WRITE_FIRST.
    logic [3:0] ram [4096];
    initial for (int i = 0; i < 4096; i++) ram[i] = 4'h3;
    always @(posedge CLK) begin
        if (EN) begin
            if (WE) begin
                ram[ADDR] <= DI;
                DO        <= DI;
            end else begin
                DO <= ram[ADDR];
            end
        end
    end

    typedef struct {
        logic [3:0] d;
        int         c;
        bit         lat;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [3:0] shadow [4096];
    int         cyc_n = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    always @(posedge CLK) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Offer one request and hold it until accepted (bounded).
    task automatic issue(input logic we, input logic [11:0] a, input logic [3:0] d, input bit lat);
        int  n  = 0;
        bit  ok = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!ok && n < 200) begin
            @(negedge CLK);
            if (req_ready) ok = 1;
            else begin
                n++;
                step();
            end
        end
        if (!ok) chk("issue_timeout", 1, 0);
        else if (we) shadow[a] = d;
        else exp_q.push_back('{d: shadow[a], c: cyc_n, lat: lat});
        step();
        req_valid = 1'b0;
    endtask

    // Response monitor / scoreboard pop.
    always @(negedge CLK) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_extra", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_data", 32'(rsp_rdata), 32'(e.d));
                if (e.lat) chk("rsp_lat", cyc_n - e.c, 2);
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return 32'({EN, WE, SSR, req_ready, rsp_valid, clr_busy, ADDR, DI, rsp_rdata});
    endfunction

    initial begin
        int errs;
        int n;
        RST = 1'b1; clr_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        for (int i = 0; i < 4096; i++) shadow[i] = 4'h3;

        // Reset and release, then the initial sweep.
        repeat (3) step();
        clr_start = 1'b1;
        @(negedge CLK);
        chk("rst_outs", all_outs(), 0);
        step();
        clr_start = 1'b0;
        RST = 1'b0;
        errs = 0;
        for (int k = 0; k <= 4097; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                chk("rel_c0_en", EN, 0);
                chk("rel_c0_busy", clr_busy, 1);
            end
            if (k >= 1 && k <= 4096)
                if (!(EN && WE && ADDR == 12'(k - 1) && DI == FILLV)) errs++;
            if (k == 4096) chk("busy_c4096", clr_busy, 1);
            if (k == 4097) begin
                chk("busy_c4097", clr_busy, 0);
                chk("ready_c4097", req_ready, 1);
            end
        end
        chk("sweep_errs", errs, 0);
        for (int i = 0; i < 4096; i++) shadow[i] = FILLV;
        step();

        // Read after clear.
        issue(1'b0, 12'h7FF, 4'h0, 1'b1);
        repeat (3) step();

        // Write then immediate read of the same address.
        issue(1'b1, 12'h123, 4'h5, 1'b0);
        issue(1'b0, 12'h123, 4'h0, 1'b1);
        repeat (3) step();

        // Distinct data at 0..15, then 16 back-to-back reads.
        for (int i = 0; i < 16; i++) issue(1'b1, 12'(i), 4'(15 - i), 1'b0);
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 12'(i), 4'h0, 1'b1);
            req_valid = 1'b1;
            #0;
        end
        req_valid = 1'b0;
        repeat (4) step();

        // Backpressure: 5 reads with rsp_ready low.
        for (int i = 0; i < 5; i++) issue(1'b1, 12'h020 + 12'(i), 4'(i + 1), 1'b0);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(1'b0, 12'h020 + 12'(i), 4'h0, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h023;
        repeat (3) step();
        @(negedge CLK);
        chk("bp_ready", req_ready, 0);
        chk("bp_accepted", exp_q.size(), 3);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_head", rsp_rdata, 4'h1);
        step();
        rsp_ready = 1'b1;
        issue(1'b0, 12'h023, 4'h0, 1'b0);
        issue(1'b0, 12'h024, 4'h0, 1'b0);
        repeat (6) step();
        chk("bp_drained", exp_q.size(), 0);

        // clr_start with one read in flight.
        issue(1'b0, 12'h005, 4'h0, 1'b1);
        clr_start = 1'b1;
        @(negedge CLK);
        chk("clr_run_busy", clr_busy, 0);
        step();
        clr_start = 1'b0;
        @(negedge CLK);
        chk("drain_busy", clr_busy, 1);
        chk("drain_ready", req_ready, 0);
        chk("drain_en", EN, 0);
        step();
        @(negedge CLK);
        chk("clr2_start", {EN, WE, clr_busy, ADDR}, {3'b111, 12'h000});
        for (int i = 0; i < 4096; i++) shadow[i] = FILLV;
        n = 0;
        while (clr_busy && n < 5000) begin
            n++;
            @(posedge CLK);
            @(negedge CLK);
        end
        chk("clr2_len", n, 4096);
        step();
        issue(1'b0, 12'h005, 4'h0, 1'b1);
        repeat (3) step();

        // Reset mid-sweep with a response parked in the FIFO.
        rsp_ready = 1'b0;
        issue(1'b0, 12'h007, 4'h0, 1'b0);
        step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!(EN && ADDR == 12'd1999) && n < 5000) begin
            n++;
            @(negedge CLK);
        end
        chk("find_1999", n < 5000, 1);
        step();
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_outs", all_outs(), 0);
        step();
        step();
        RST = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        chk("rel2_c0", {EN, rsp_valid, clr_busy}, 3'b001);
        step();
        @(negedge CLK);
        chk("rel2_restart", {EN, WE, ADDR}, {2'b11, 12'h000});
        rsp_ready = 1'b1;
        n = 0;
        while (clr_busy && n < 5000) begin
            n++;
            @(negedge CLK);
        end
        chk("rel2_len", n, 4096);
        step();
        issue(1'b0, 12'hFFF, 4'h0, 1'b1);
        repeat (5) step();
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bram_s4_port_ctrl.md
# bram_s4_port_ctrl

Single-clock initiator for one port of a 4096 x 4-bit block RAM primitive in the unisim library. It converts a valid/ready request stream into the RAM's ADDR/DI/EN/WE/SSR pin protocol and returns read data on a valid/ready response stream. A 3-entry skid FIFO absorbs the RAM's one-cycle read latency under backpressure. After reset, and on command, it sweeps the entire array to a fill value.

## Interface
- FILL, 4'h0, value written to every location during a clear sweep
- DEPTH_LOG2, 12, address width; the clear sweep covers 0 to 2^DEPTH_LOG2-1
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- clr_start  in  1  one-cycle pulse that requests a clear sweep
- clr_busy  out  1  high while a clear is pending or in progress
- req_valid / req_ready  in / out  1 / 1  request handshake
- req_we  in  1  1 = write, 0 = read
- req_addr  in  12  word address
- req_wdata  in  4  write data
- rsp_valid / rsp_ready  out / in  1 / 1  read-response handshake
- rsp_rdata  out  4  read data
- ADDR, DI, EN, WE, SSR  out  12, 4, 1, 1, 1  drive the RAM port
- DO  in  4  RAM port output

## Operation
- States: RESET, CLEAR, RUN, DRAIN.
- RST high: every output is 0 and the state is RESET. The first cycle after RST falls enters CLEAR with clr_busy=1.
- CLEAR:
  - 12-bit counter clr_addr starts at 0.
  - Each cycle drives EN=1, WE=1, ADDR=clr_addr, DI=FILL.
  - clr_addr increments each cycle.
  - At clr_addr=4095 the state goes to RUN. The counter wraps to 0.
  - The sweep takes exactly 4096 cycles. req_ready=0 throughout.
- RUN:
  - req_ready = (fifo_cnt + pend) < 3, where pend is the read issued in the previous cycle. There is no combinational path from rsp_ready to req_ready.
  - The RAM pins are combinational from the accepted request: EN = req_valid & req_ready, WE = EN & req_we, ADDR = req_addr, DI = req_wdata.
  - Writes produce no response.
  - A read sets pend for one cycle. DO is pushed into the FIFO on the following edge.
- The FIFO is in-order, 3 entries deep. rsp_valid = (fifo_cnt != 0) and rsp_rdata is the head entry. A push and a pop in the same cycle leave the count unchanged.
- clr_start:
  - In RUN: go to DRAIN. req_ready=0 and clr_busy=1 from the next cycle.
  - DRAIN waits for pend=0, then enters CLEAR. FIFO contents are kept and remain poppable.
  - In CLEAR or DRAIN: ignored; the sweep is not restarted.
  - During RST: ignored.
- SSR is held at 0. Output reset is not used.
- Read-after-write to the same address on back-to-back cycles returns the new data. This relies on the RAM's WRITE_FIRST ordering. The controller adds no bypass.
- RST mid-sweep or mid-read: the sweep restarts from 0, the FIFO is flushed, and pend is cleared. Responses still outstanding are lost.

## Timing
- Read accepted at edge t (RAM samples at t). DO is valid in cycle t+1, pushed at edge t+1, and rsp_valid is high in the cycle after edge t+1. Minimum latency is 2 cycles.
- Sustained throughput is 1 read/cycle with rsp_ready held high (fifo_cnt + pend ≤ 2).
- With rsp_ready low, at most 3 reads are accepted before req_ready drops. Writes are also blocked, because req_ready does not distinguish request types.
- clr_busy falls in the first RUN cycle. With no intervening reset, req_ready can rise in that same cycle.

## Structure
- Shared package bram_ctrl_pkg holds:
  - the state enum
  - ADDR_W=12 and DATA_W=4
  - RSP_FIFO_DEPTH=3
- Sub-module bram_rsp_fifo: a generic synchronous FIFO with count output, DEPTH and WIDTH parameters, and synchronous active-high reset.
- Top-level RTL holds the state machine, the clear counter, the pend flag and the pin muxing.

## Test plan
- Reset release with FILL=4'hA:
  - Exactly 4096 cycles of EN=WE=1 with ADDR going 0 to 4095.
  - clr_busy falls at cycle 4097.
  - A subsequent read of address 0x7FF returns 4'hA.
- Write 0x123←4'h5, then read 0x123 on the next cycle: rsp_rdata=4'h5 two cycles after the read is accepted.
- 16 back-to-back reads of addresses 0..15 with rsp_ready=1: req_ready stays high, and 16 responses arrive in address order on consecutive cycles.
- rsp_ready=0 with 5 reads offered: exactly 3 are accepted and req_ready=0. Releasing rsp_ready drains 3 responses in order, then the remaining 2 are accepted.
- clr_start while one read is in flight:
  - The read response is still delivered.
  - The sweep starts one cycle after pend clears.
  - clr_busy=1 throughout.
- RST asserted at clr_addr=2000: all outputs are 0 during RST, and the sweep restarts from ADDR=0 after release.
